// File: rtl/burrito_sequencer_if.sv
// Instruction handshake and datapath-control bundle between an instruction source,
// the sequencer, and the Burrito register-file/ALU.
interface burrito_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             InstrValid;
  logic [31:0]      InstrData;
  logic             InstrReady;
  logic             RegWrite;
  logic [4:0]       Addr_op1;
  logic [4:0]       Addr_op2;
  logic [4:0]       Addr_Destino;
  logic [2:0]       Operacion;
  logic             Busy;
  logic             Halted;
  logic [CNT_W-1:0] Retired;

  modport slave (
    input  InstrValid, InstrData,
    output InstrReady, RegWrite, Addr_op1, Addr_op2, Addr_Destino,
           Operacion, Busy, Halted, Retired
  );

  modport master (
    output InstrValid, InstrData,
    input  InstrReady, RegWrite, Addr_op1, Addr_op2, Addr_Destino,
           Operacion, Busy, Halted, Retired
  );
endinterface

// File: rtl/burrito_sequencer.sv
// Decodes 32-bit instruction words into Burrito datapath controls, with per-word
// repeat (vector) execution, address auto-increment and a terminal HALT.
module burrito_sequencer #(
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  burrito_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_HALTED} state_t;

  localparam logic [1:0] K_ALU  = 2'b01;
  localparam logic [1:0] K_HALT = 2'b11;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [4:0]       r_dest;
  logic [4:0]       r_op1;
  logic [4:0]       r_op2;
  logic             r_is_alu;
  logic             r_inc;
  logic [7:0]       r_rep;
  logic [7:0]       r_iter;
  logic             r_regwrite;
  logic             r_ready;
  logic             r_busy;
  logic             r_halted;
  logic [CNT_W-1:0] r_retired;

  logic       w_accept;
  logic [1:0] w_kind;
  logic       w_unused_bits;

  assign w_accept      = bus.InstrValid && r_ready;
  assign w_kind        = bus.InstrData[13:12];
  assign w_unused_bits = ^bus.InstrData[11:9];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_dest     <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_is_alu   <= 1'b0;
      r_inc      <= 1'b0;
      r_rep      <= '0;
      r_iter     <= '0;
      r_regwrite <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_retired  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            if (w_kind == K_HALT) begin
              r_state  <= S_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_op     <= bus.InstrData[31:29];
              r_dest   <= bus.InstrData[28:24];
              r_op1    <= bus.InstrData[23:19];
              r_op2    <= bus.InstrData[18:14];
              r_is_alu <= (w_kind == K_ALU);
              r_inc    <= bus.InstrData[8];
              r_rep    <= bus.InstrData[7:0];
              r_iter   <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          r_regwrite <= r_is_alu;
          r_state    <= S_WRITE;
        end
        S_WRITE: begin
          // Addresses advance on the same edge RegWrite falls, so a write never sees them move.
          r_regwrite <= 1'b0;
          if (r_is_alu && (r_iter < r_rep)) begin
            r_iter <= r_iter + 8'd1;
            r_dest <= r_dest + 5'd1;
            if (r_inc) begin
              r_op1 <= r_op1 + 5'd1;
              r_op2 <= r_op2 + 5'd1;
            end
            r_state <= S_SETUP;
          end else begin
            r_retired <= r_retired + CNT_W'(1);
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_HALTED: begin
          r_regwrite <= 1'b0;
          r_ready    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.InstrReady   = r_ready;
  assign bus.RegWrite     = r_regwrite;
  assign bus.Addr_op1     = r_op1;
  assign bus.Addr_op2     = r_op2;
  assign bus.Addr_Destino = r_dest;
  assign bus.Operacion    = r_op;
  assign bus.Busy         = r_busy;
  assign bus.Halted       = r_halted;
  assign bus.Retired      = r_retired;

endmodule

// File: tb/tb_burrito_sequencer.sv
// Randomized bench for burrito_sequencer against a per-instruction transaction model
// that predicts write events, occupancy windows and the retired count.
module tb_burrito_sequencer;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  burrito_sequencer_if #(.CNT_W(CNT_W)) bus();
  burrito_sequencer #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int         cyc;
    logic [2:0] op;
    logic [4:0] d;
    logic [4:0] a;
    logic [4:0] b;
  } wr_t;

  wr_t        exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         free_cyc = 0;
  int         ret_at = 0;
  int         m_ret = 0;
  int         n_acc = 0;
  bit         ret_pend = 0;
  bit         m_halted = 0;
  logic [4:0] last_d = '0, last_a = '0, last_b = '0;
  logic [2:0] last_op = '0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(logic [2:0] op, logic [1:0] kind, logic [4:0] d,
                                     logic [4:0] a, logic [4:0] b, logic inc, logic [7:0] r);
    logic [2:0] junk;
    junk = 3'($urandom);
    return {op, d, a, b, kind, junk, inc, r};
  endfunction

  // Reference model: each accepted word expands into its list of timed write events.
  task automatic model_accept(logic [31:0] w);
    logic [1:0] kind;
    int         n;
    int         di, ai, bi;
    wr_t        e;
    kind = w[13:12];
    n_acc++;
    if (kind == 2'b11) begin
      m_halted = 1;
      return;
    end
    n = (kind == 2'b01) ? int'(w[7:0]) + 1 : 1;
    for (int i = 0; i < n; i++) begin
      di = (int'(w[28:24]) + i) % 32;
      ai = (int'(w[23:19]) + (w[8] ? i : 0)) % 32;
      bi = (int'(w[18:14]) + (w[8] ? i : 0)) % 32;
      if (kind == 2'b01) begin
        e.cyc = cyc + 2 + 2 * i;
        e.op  = w[31:29];
        e.d   = 5'(di);
        e.a   = 5'(ai);
        e.b   = 5'(bi);
        exp_q.push_back(e);
      end
      last_d = 5'(di);
      last_a = 5'(ai);
      last_b = 5'(bi);
    end
    last_op  = w[31:29];
    free_cyc = cyc + 1 + 2 * n;
    ret_at   = free_cyc;
    ret_pend = 1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit er, eb, erw;
    if (ret_pend && cyc >= ret_at) begin
      m_ret++;
      ret_pend = 0;
    end
    er  = !m_halted && (cyc >= free_cyc);
    eb  = !m_halted && !er;
    erw = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    chk("ready", bus.InstrReady, er);
    chk("busy", bus.Busy, eb);
    chk("halted", bus.Halted, m_halted);
    chk("retired", bus.Retired, m_ret % (1 << CNT_W));
    chk("regwrite", bus.RegWrite, erw);
    if (erw) begin
      chk("wr_op", bus.Operacion, exp_q[0].op);
      chk("wr_dest", bus.Addr_Destino, exp_q[0].d);
      chk("wr_op1", bus.Addr_op1, exp_q[0].a);
      chk("wr_op2", bus.Addr_op2, exp_q[0].b);
      void'(exp_q.pop_front());
    end
    if (er || m_halted) begin
      chk("hold_dest", bus.Addr_Destino, last_d);
      chk("hold_op1", bus.Addr_op1, last_a);
      chk("hold_op2", bus.Addr_op2, last_b);
      chk("hold_opc", bus.Operacion, last_op);
    end
    if (rst) begin
      exp_q.delete();
      ret_pend = 0;
      m_ret    = 0;
      m_halted = 0;
      free_cyc = cyc + 1;
      last_d   = '0;
      last_a   = '0;
      last_b   = '0;
      last_op  = '0;
    end else if (bus.InstrValid && er) begin
      model_accept(bus.InstrData);
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic [31:0] w);
    int start;
    start = n_acc;
    bus.InstrValid = 1'b1;
    bus.InstrData  = w;
    for (int t = 0; t < 1200 && n_acc == start; t++) @(posedge clk);
    #1;
    chk("accepted", n_acc - start, 1);
    bus.InstrValid = 1'b0;
    bus.InstrData  = $urandom;
  endtask

  task automatic offer(logic [31:0] w, int n);
    bus.InstrValid = 1'b1;
    bus.InstrData  = w;
    idle(n);
    bus.InstrValid = 1'b0;
  endtask

  initial begin
    logic [1:0] kinds [5];
    kinds = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
    bus.InstrValid = 1'b0;
    bus.InstrData  = '0;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset abandoned mid-SETUP: no write, nothing retired
    send(mk(3'b101, 2'b01, 5'd9, 5'd3, 5'd4, 1'b0, 8'd0));
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);

    send(mk(3'b010, 2'b01, 5'd7, 5'd1, 5'd2, 1'b0, 8'd0));
    idle(4);
    send(mk(3'b110, 2'b01, 5'd30, 5'd31, 5'd5, 1'b1, 8'd2));
    idle(8);
    send(mk(3'b001, 2'b00, 5'd12, 5'd13, 5'd14, 1'b1, 8'd9));
    send(mk(3'b011, 2'b10, 5'd15, 5'd16, 5'd17, 1'b0, 8'd4));
    idle(3);

    for (int i = 0; i < 4; i++)
      send(mk(3'($urandom), 2'b01, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 8'd0));
    idle(3);

    for (int i = 0; i < 300; i++) begin
      send(mk(3'($urandom), kinds[$urandom_range(0, 4)], 5'($urandom), 5'($urandom),
              5'($urandom), 1'($urandom), 8'($urandom_range(0, 4))));
      idle($urandom_range(0, 3));
    end

    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(mk(3'b100, 2'b01, 5'd3, 5'd4, 5'd5, 1'b0, 8'd0));
    send(mk(3'b000, 2'b11, 5'd0, 5'd0, 5'd0, 1'b0, 8'd0));
    offer(mk(3'b111, 2'b01, 5'd20, 5'd21, 5'd22, 1'b0, 8'd0), 10);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);

    @(negedge clk);
    chk("pending_writes", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
